// File: rtl/ps2_transmitter_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter: state encoding,
// default timing, command bytes and frame construction.
package ps2_transmitter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_state_t;

    localparam int DEF_INHIBIT_CYCLES = 5000;    // 100 us at 50 MHz
    localparam int DEF_TIMEOUT_CYCLES = 750000;  // 15 ms at 50 MHz
    localparam int CNT_W              = 20;
    localparam int FRAME_W            = 10;      // 8 data + parity + stop
    localparam int LAST_SHIFT_EDGE    = 10;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESEND   = 8'hFE;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

    typedef struct packed {
        logic done;
        logic nack;
        logic timeout;
    } ps2_status_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Shifted out LSB first after the start bit; stop bit sits at the top.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [7:0] d);
        return {1'b1, odd_parity(d), d};
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line with falling-edge detect.
module ps2_line_sync (
    input  logic clk_50Mhz,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Idle bus level is high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], line_in};
            prev_q <= sync_q[1];
        end
    end

    assign line_sync = sync_q[1];
    assign fall      = prev_q & ~sync_q[1];

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked
// shift of data/parity/stop under device clock, ack check and watchdog.
module ps2_transmitter
    import ps2_transmitter_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk_50Mhz,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       EDGE_TO_ACK  = 4'(LAST_SHIFT_EDGE - 1);

    ps2_state_t         state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [3:0]         edge_q, edge_n;
    logic [FRAME_W-1:0] sh_q, sh_n;
    logic               dq_q, dq_n;
    ps2_status_t        stat_q, stat_n;

    logic clk_sync, clk_fall;
    logic data_sync, unused_data_fall;
    logic watched;

    ps2_line_sync u_clk_sync (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_sync),
        .fall      (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk_50Mhz (clk_50Mhz),
        .rst       (rst),
        .line_in   (ps2_data_in),
        .line_sync (data_sync),
        .fall      (unused_data_fall)
    );

    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            sh_q    <= '0;
            dq_q    <= 1'b0;
            stat_q  <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            edge_q  <= edge_n;
            sh_q    <= sh_n;
            dq_q    <= dq_n;
            stat_q  <= stat_n;
        end
    end

    assign watched = (state_q == ST_REQUEST) || (state_q == ST_SHIFT) ||
                     (state_q == ST_ACK)     || (state_q == ST_WAIT_IDLE);

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        edge_n      = edge_q;
        sh_n        = sh_q;
        dq_n        = dq_q;
        stat_n      = '0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A start landing on a completion pulse is dropped on purpose.
                if (tx_start && (stat_q == '0)) begin
                    sh_n    = build_frame(tx_data);
                    cnt_n   = '0;
                    edge_n  = '0;
                    dq_n    = 1'b0;
                    state_n = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (cnt_q == INHIBIT_LAST);
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_REQUEST;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_REQUEST: ps2_data_oe = 1'b1;
            ST_SHIFT:   ps2_data_oe = dq_q;
            ST_ACK, ST_WAIT_IDLE: ;
            default:    state_n = ST_IDLE;
        endcase

        if (watched) begin
            cnt_n = clk_fall ? '0 : cnt_q + 1'b1;
            if (clk_fall) begin
                case (state_q)
                    ST_REQUEST, ST_SHIFT: begin
                        // Host changes data on the falling edge; device samples while high.
                        dq_n    = ~sh_q[0];
                        sh_n    = {1'b1, sh_q[FRAME_W-1:1]};
                        edge_n  = edge_q + 1'b1;
                        state_n = (edge_q == EDGE_TO_ACK) ? ST_ACK : ST_SHIFT;
                    end
                    ST_ACK: begin
                        if (data_sync) begin
                            stat_n.nack = 1'b1;
                            state_n     = ST_IDLE;
                        end else begin
                            state_n = ST_WAIT_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
            if ((state_q == ST_WAIT_IDLE) && clk_sync && data_sync) begin
                stat_n.done = 1'b1;
                state_n     = ST_IDLE;
            end else if (!clk_fall && (cnt_q == TIMEOUT_LAST)) begin
                stat_n.timeout = 1'b1;
                state_n        = ST_IDLE;
            end
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = stat_q.done;
    assign nack    = stat_q.nack;
    assign timeout = stat_q.timeout;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a behavioural open-drain PS/2 device.
module tb_ps2_transmitter;
    import ps2_transmitter_pkg::*;

    logic       clk_50Mhz = 1'b0;
    logic       rst       = 1'b1;
    logic       tx_start  = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       dev_clk   = 1'b1;
    logic       dev_data  = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, nack, timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done = 0, n_nack = 0, n_tmo = 0, n_multi = 0, n_pulse_busy = 0;
    int run = 0, last_run = 0, inhib_data = 0;
    logic busy_prev = 1'b0;

    assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_transmitter #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(200)) dut (
        .clk_50Mhz   (clk_50Mhz),
        .rst         (rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .nack        (nack),
        .timeout     (timeout)
    );

    always #10 clk_50Mhz = ~clk_50Mhz;

    // Passive monitor: pulse counts, pulse/busy relation, inhibit run length.
    always @(negedge clk_50Mhz) begin
        if (done)    n_done++;
        if (nack)    n_nack++;
        if (timeout) n_tmo++;
        if (int'(done) + int'(nack) + int'(timeout) > 1) n_multi++;
        if ((done || nack || timeout) && (busy || !busy_prev)) n_pulse_busy++;
        busy_prev = busy;
        if (ps2_clk_oe) begin
            run++;
            if (ps2_data_oe) inhib_data++;
        end else if (run != 0) begin
            last_run = run;
            run      = 0;
        end
    end

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk_50Mhz);
        tx_start = 1'b0;
        tx_data  = 8'h00;
    endtask

    // Device: waits for request-to-send, then issues n_fall clock pulses of
    // 40 cycles, recording the data line while clock is high.
    task automatic device_xfer(input int n_fall, input logic ack_bit,
                               output logic [10:0] frame, output bit ok);
        int w;
        frame    = '0;
        ok       = 1'b1;
        dev_data = 1'b1;
        w        = 0;
        while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 2000) begin
            @(negedge clk_50Mhz);
            w++;
        end
        if (w >= 2000) begin
            ok = 1'b0;
            return;
        end
        repeat (20) @(negedge clk_50Mhz);
        frame[0] = ps2_data_in;
        for (int e = 1; e <= n_fall; e++) begin
            dev_clk = 1'b0;
            repeat (20) @(negedge clk_50Mhz);
            dev_clk = 1'b1;
            if (e <= 10) frame[e] = ps2_data_in;
            if (e == 10) dev_data = ack_bit;
            if (e == 11) dev_data = 1'b1;
            repeat (20) @(negedge clk_50Mhz);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_50Mhz);
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_lines: got clk_oe/data_oe/busy=%b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        n_checks++;
        if ({done, nack, timeout} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b expected 000", {done, nack, timeout});
        end
        rst = 1'b0;
        @(negedge clk_50Mhz);
    endtask

    task automatic test_send_ack();
        logic [10:0] fr;
        bit ok;
        int d0, k0, t0, i0;
        d0 = n_done; k0 = n_nack; t0 = n_tmo; i0 = inhib_data;
        start_tx(PS2_CMD_SET_LEDS);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_busy_start: got %b expected 1", busy);
        end
        device_xfer(11, 1'b0, fr, ok);
        repeat (10) @(negedge clk_50Mhz);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ack_request: got no request expected request"); end
        n_checks++;
        if (fr !== 11'b1_1_11101101_0) begin
            n_fail++;
            $display("FAIL ack_frame: got %b expected %b", fr, 11'b1_1_11101101_0);
        end
        n_checks++;
        if (last_run !== 10) begin n_fail++; $display("FAIL ack_inhibit_len: got %0d expected 10", last_run); end
        n_checks++;
        if (inhib_data - i0 !== 1) begin
            n_fail++;
            $display("FAIL ack_inhibit_data: got %0d expected 1", inhib_data - i0);
        end
        n_checks++;
        if ({n_done - d0, n_nack - k0, n_tmo - t0} !== {32'd1, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL ack_pulses: got done=%0d nack=%0d tmo=%0d expected 1/0/0", n_done - d0, n_nack - k0, n_tmo - t0);
        end
        n_checks++;
        if (n_pulse_busy !== 0) begin n_fail++; $display("FAIL ack_busy_vs_done: got %0d expected 0", n_pulse_busy); end
    endtask

    task automatic test_nack();
        logic [10:0] fr;
        bit ok;
        int d0, k0, t0;
        d0 = n_done; k0 = n_nack; t0 = n_tmo;
        start_tx(8'h07);
        device_xfer(11, 1'b1, fr, ok);
        repeat (10) @(negedge clk_50Mhz);
        n_checks++;
        if (fr !== 11'b1_0_00000111_0) begin
            n_fail++;
            $display("FAIL nack_frame: got %b expected %b", fr, 11'b1_0_00000111_0);
        end
        n_checks++;
        if ({n_done - d0, n_nack - k0, n_tmo - t0} !== {32'd0, 32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL nack_pulses: got done=%0d nack=%0d tmo=%0d expected 0/1/0", n_done - d0, n_nack - k0, n_tmo - t0);
        end
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL nack_release: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
    endtask

    task automatic test_timeout_no_clock();
        int w, n;
        start_tx(8'h00);
        w = 0;
        while (ps2_clk_oe === 1'b1 && w < 100) begin @(negedge clk_50Mhz); w++; end
        n = 0;
        while (ps2_data_oe === 1'b1 && n < 1000) begin @(negedge clk_50Mhz); n++; end
        n_checks++;
        if (n !== 200) begin n_fail++; $display("FAIL tmo_request_len: got %0d expected 200", n); end
        n_checks++;
        if ({timeout, ps2_clk_oe, ps2_data_oe, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL tmo_pulse: got tmo/clk_oe/data_oe/busy=%b expected 1000", {timeout, ps2_clk_oe, ps2_data_oe, busy});
        end
        @(negedge clk_50Mhz);
        n_checks++;
        if ({timeout, done, nack} !== 3'b000) begin
            n_fail++;
            $display("FAIL tmo_one_cycle: got %b expected 000", {timeout, done, nack});
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] fr;
        bit ok;
        int d0, w;
        d0 = n_done;
        w  = 0;
        start_tx(PS2_CMD_SET_LEDS);
        fork
            device_xfer(11, 1'b0, fr, ok);
            begin
                repeat (150) @(negedge clk_50Mhz);
                start_tx(PS2_CMD_RESET);
            end
            begin
                while (done !== 1'b1 && w < 3000) begin @(negedge clk_50Mhz); w++; end
                tx_data  = PS2_CMD_RESET;
                tx_start = 1'b1;
                @(negedge clk_50Mhz);
                tx_start = 1'b0;
            end
        join
        repeat (5) @(negedge clk_50Mhz);
        n_checks++;
        if (w >= 3000) begin n_fail++; $display("FAIL b2b_done_wait: got no done within %0d cycles expected done", w); end
        n_checks++;
        if (fr !== 11'b1_1_11101101_0) begin
            n_fail++;
            $display("FAIL b2b_frame: got %b expected %b", fr, 11'b1_1_11101101_0);
        end
        n_checks++;
        if (n_done - d0 !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", n_done - d0); end
        n_checks++;
        if ({busy, ps2_clk_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_start_on_done: got busy/clk_oe=%b expected 00", {busy, ps2_clk_oe});
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] fr;
        bit ok;
        int d0, k0, t0;
        start_tx(PS2_CMD_RESEND);
        device_xfer(4, 1'b0, fr, ok);
        dev_clk = 1'b0;
        repeat (5) @(negedge clk_50Mhz);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        d0 = n_done; k0 = n_nack; t0 = n_tmo;
        rst = 1'b1;
        @(negedge clk_50Mhz);
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_release: got %b expected 000", {ps2_clk_oe, ps2_data_oe, busy});
        end
        rst     = 1'b0;
        dev_clk = 1'b1;
        repeat (300) @(negedge clk_50Mhz);
        n_checks++;
        if ({n_done - d0, n_nack - k0, n_tmo - t0} !== {32'd0, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL rstmid_no_pulse: got done=%0d nack=%0d tmo=%0d expected 0/0/0", n_done - d0, n_nack - k0, n_tmo - t0);
        end
        d0 = n_done;
        start_tx(PS2_CMD_RESEND);
        device_xfer(11, 1'b0, fr, ok);
        repeat (10) @(negedge clk_50Mhz);
        n_checks++;
        if (fr !== 11'b1_0_11111110_0) begin
            n_fail++;
            $display("FAIL rstmid_frame: got %b expected %b", fr, 11'b1_0_11111110_0);
        end
        n_checks++;
        if (n_done - d0 !== 1) begin n_fail++; $display("FAIL rstmid_done: got %0d expected 1", n_done - d0); end
    endtask

    task automatic test_stall();
        logic [10:0] fr;
        bit ok;
        int d0, k0, w;
        d0 = n_done; k0 = n_nack;
        start_tx(8'h3C);
        device_xfer(6, 1'b0, fr, ok);
        w = 0;
        while (timeout !== 1'b1 && w < 250) begin @(negedge clk_50Mhz); w++; end
        n_checks++;
        if (w >= 250) begin n_fail++; $display("FAIL stall_timeout: got no timeout in %0d cycles expected pulse", w); end
        n_checks++;
        if (fr[6:0] !== 7'b1111000) begin n_fail++; $display("FAIL stall_bits: got %b expected 1111000", fr[6:0]); end
        repeat (5) @(negedge clk_50Mhz);
        n_checks++;
        if ({n_done - d0, n_nack - k0} !== {32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL stall_other_pulses: got done=%0d nack=%0d expected 0/0", n_done - d0, n_nack - k0);
        end
        d0 = n_done;
        start_tx(PS2_CMD_SET_LEDS);
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_restart_inhibit: got clk_oe/data_oe=%b expected 10", {ps2_clk_oe, ps2_data_oe});
        end
        device_xfer(11, 1'b0, fr, ok);
        repeat (10) @(negedge clk_50Mhz);
        n_checks++;
        if (fr !== 11'b1_1_11101101_0 || last_run !== 10) begin
            n_fail++;
            $display("FAIL stall_restart_frame: got %b run=%0d expected %b run=10", fr, last_run, 11'b1_1_11101101_0);
        end
        n_checks++;
        if (n_done - d0 !== 1) begin n_fail++; $display("FAIL stall_restart_done: got %0d expected 1", n_done - d0); end
    endtask

    initial begin
        test_reset();
        test_send_ack();
        test_nack();
        test_timeout_no_clock();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        n_checks++;
        if (n_multi !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_multi); end
        n_checks++;
        if (n_pulse_busy !== 0) begin n_fail++; $display("FAIL pulse_busy: got %0d expected 0", n_pulse_busy); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_transmitter.md
PS2_TRANSMITTER -- requirements
Module: ps2_transmitter

Interface
REQ-001 The block SHALL have parameter INHIBIT_CYCLES, default 5000, meaning clk_50Mhz cycles ps2 clock is held low before the request (100 us).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 750000, meaning the maximum cycles between device clock falling edges, or from request to first edge (15 ms).
REQ-003 The block SHALL have ports (clock and reset first): clk_50Mhz in 1 system clock; rst in 1 reset (one clock; reset is synchronous and active-high); tx_start in 1 send request; tx_data in 8 byte to send; ps2_clk_in in 1 raw clock line; ps2_data_in in 1 raw data line; ps2_clk_oe out 1 drive clock line low; ps2_data_oe out 1 drive data line low; busy out 1 transfer in progress / receiver inhibit; done out 1 acknowledged; nack out 1 no ack; timeout out 1 device silent.

Function
REQ-004 The block SHALL pass ps2_clk_in and ps2_data_in through 2-flop synchronizers and detect falling edges on the synchronized clock (prev=1, now=0).
REQ-005 The block SHALL implement states IDLE, INHIBIT, REQUEST, SHIFT, ACK, WAIT_IDLE.
REQ-006 IDLE: tx_start=1 SHALL latch tx_data, compute odd parity (~^tx_data), clear the counter, and enter INHIBIT; busy=1 from the next cycle.
REQ-007 INHIBIT: ps2_clk_oe SHALL be 1 for exactly INHIBIT_CYCLES cycles; ps2_data_oe SHALL be 1 in the last of them; then the block SHALL enter REQUEST.
REQ-008 REQUEST: ps2_clk_oe=0 and ps2_data_oe=1 (start bit 0) SHALL hold until the first device falling edge.
REQ-009 SHIFT: on falling edges 1-8, ps2_data_oe SHALL become ~bit[k-1] (LSB first); edge 9 parity; edge 10 ps2_data_oe=0 (stop bit released); then ACK.
REQ-010 ACK: on falling edge 11 the block SHALL sample synchronized data; 0 = ack and enter WAIT_IDLE; 1 = one-cycle nack pulse and return to IDLE.
REQ-011 WAIT_IDLE: once synchronized clock and data both read 1, the block SHALL pulse done for one cycle and return to IDLE.
REQ-012 In REQUEST, SHIFT, ACK and WAIT_IDLE, a watchdog counter SHALL reset on every falling edge; reaching TIMEOUT_CYCLES SHALL release both lines, pulse timeout for one cycle and return to IDLE.
REQ-013 tx_start while busy=1 SHALL be ignored; tx_data SHALL be sampled only in IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE, and 0 in the cycle done/nack/timeout pulses.
REQ-015 done, nack and timeout SHALL be mutually exclusive, one per transfer.
REQ-016 A tx_start coincident with a done/nack/timeout pulse SHALL be ignored; a new transfer requires tx_start in IDLE.
REQ-017 The counter SHALL be 20 bits and hold values up to 750000 without wrap.

Reset
REQ-018 On rst=1 at a clock edge, all outputs SHALL be 0 (both lines released), state IDLE, counter, bit index, shift register and synchronizers cleared (synchronizers to 1).
REQ-019 Reset asserted mid-transfer SHALL release both lines on the next edge, with no done/nack/timeout pulse.

Structure
REQ-020 A shared package SHALL hold the state encoding, the default INHIBIT_CYCLES/TIMEOUT_CYCLES, and the PS/2 command constants (0xED set LEDs, 0xFE resend, 0xFF reset).
REQ-021 One sub-module, ps2_line_sync (2-flop synchronizer plus falling-edge detect), SHALL be instantiated per line.
REQ-022 Line drivers (pad = oe ? 0 : Z) SHALL stay outside this block.

Verification (bench: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200, device model clock period 40 cycles)
REQ-023 Send 0xED, model acks -> clk_oe high exactly 10 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one done pulse; busy falls with done.
REQ-024 Send 0x07, model leaves data high on edge 11 -> parity 0 observed; one nack pulse; lines released; no done.
REQ-025 Send 0x00, model never clocks -> ps2_data_oe=1 for 200 cycles after REQUEST entry, then one timeout pulse, both oe 0.
REQ-026 tx_start with 0xFF during a 0xED transfer -> ignored; the 0xED bit pattern is unchanged; exactly one done.
REQ-027 rst=1 at falling edge 5 of a 0xFE transfer -> both oe 0 and busy 0 the next cycle, no pulses; a following 0xFE transfer completes with done.
REQ-028 Model stalls 250 cycles after edge 6 -> timeout pulse; the next transfer starts cleanly from INHIBIT.
